// File: rtl/ex_operand_issue.sv
// ID/EX stage: registers the decoded instruction, forwards ALU operands from
// EX/MEM and MEM/WB, detects load-use hazards and inserts bubbles on flush/stall.
module ex_operand_issue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RBITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RBITS-1:0] id_rs,
    input  logic [RBITS-1:0] id_rt,
    input  logic [RBITS-1:0] id_rd,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_shamt,
    input  logic [1:0]       id_op,
    input  logic             id_alu_src_imm,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic [RBITS-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RBITS-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic             stall,
    output logic [5:0]       ex_funct,
    output logic [1:0]       ex_op,
    output logic [4:0]       ex_shamt,
    output logic [WIDTH-1:0] ex_src1,
    output logic [WIDTH-1:0] ex_src2,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RBITS-1:0] ex_dest,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write
);

    logic             valid_q;
    logic             reg_write_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic             alu_src_imm_q;
    logic [5:0]       funct_q;
    logic [1:0]       op_q;
    logic [4:0]       shamt_q;
    logic [RBITS-1:0] rs_q;
    logic [RBITS-1:0] rt_q;
    logic [RBITS-1:0] dest_q;
    logic [WIDTH-1:0] rs_val_q;
    logic [WIDTH-1:0] rt_val_q;
    logic [WIDTH-1:0] imm_q;

    logic             hz;
    logic             load;
    logic [WIDTH-1:0] rs_cap;
    logic [WIDTH-1:0] rt_cap;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        hz = valid_q & mem_read_q & (dest_q != '0) & id_valid &
             ((dest_q == id_rs) | (dest_q == id_rt));
    end

    assign stall = hz & ~flush;
    // Invalid decode slots are captured as zeroed bubbles too.
    assign load  = id_valid & ~flush & ~hz;

    // Same-cycle register-file write: take the WB value instead of stale read data.
    always_comb begin
        rs_cap = id_rs_data;
        rt_cap = id_rt_data;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs)) begin
            rs_cap = memwb_result;
        end
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rt)) begin
            rt_cap = memwb_result;
        end
    end

    // ID/EX register: reset and bubbles clear every field, otherwise capture.
    always_ff @(posedge clk) begin
        if (rst || !load) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            alu_src_imm_q <= 1'b0;
            funct_q       <= '0;
            op_q          <= '0;
            shamt_q       <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            dest_q        <= '0;
            rs_val_q      <= '0;
            rt_val_q      <= '0;
            imm_q         <= '0;
        end else begin
            valid_q       <= 1'b1;
            reg_write_q   <= id_reg_write;
            mem_read_q    <= id_mem_read;
            mem_write_q   <= id_mem_write;
            alu_src_imm_q <= id_alu_src_imm;
            funct_q       <= id_funct;
            op_q          <= id_op;
            shamt_q       <= id_shamt;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            dest_q        <= id_reg_dst ? id_rd : id_rt;
            rs_val_q      <= rs_cap;
            rt_val_q      <= rt_cap;
            imm_q         <= id_imm;
        end
    end

    // Operand forwarding: EX/MEM is newer than MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_a = rs_val_q;
        fwd_b = rt_val_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
            fwd_a = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
            fwd_a = memwb_result;
        end
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
            fwd_b = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
            fwd_b = memwb_result;
        end
    end

    assign ex_src1       = fwd_a;
    assign ex_src2       = alu_src_imm_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign ex_funct      = funct_q;
    assign ex_op         = op_q;
    assign ex_shamt      = shamt_q;
    assign ex_dest       = dest_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_ex_operand_issue.sv
// Scoreboard bench for ex_operand_issue: directed hazard/forwarding scenarios
// followed by randomized traffic, checked against an instruction-level model.
module tb_ex_operand_issue;

    typedef struct packed {
        logic        rst;
        logic        id_valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic        src_imm;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        flush;
        logic        xm_rw;
        logic [4:0]  xm_rd;
        logic [31:0] xm_res;
        logic        mw_rw;
        logic [4:0]  mw_rd;
        logic [31:0] mw_res;
    } stim_t;

    // The instruction currently sitting in EX, as the model sees it.
    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        src_imm;
        logic [5:0]  funct;
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
    } ex_t;

    typedef struct packed {
        logic        stall;
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [5:0]  funct;
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] store;
        logic [4:0]  dest;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt;
    logic [1:0]  id_op;
    logic        id_alu_src_imm, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        stall;
    logic [5:0]  ex_funct;
    logic [1:0]  ex_op;
    logic [4:0]  ex_shamt;
    logic [31:0] ex_src1, ex_src2, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;

    int    n_checks = 0;
    int    n_fail   = 0;
    out_t  exp_q[$];
    ex_t   model;
    stim_t prev;

    always #5 clk = ~clk;

    ex_operand_issue #(.WIDTH(32), .RBITS(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_funct(id_funct), .id_shamt(id_shamt), .id_op(id_op),
        .id_alu_src_imm(id_alu_src_imm), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result), .stall(stall),
        .ex_funct(ex_funct), .ex_op(ex_op), .ex_shamt(ex_shamt),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic load_use(input ex_t m, input stim_t s);
        return m.valid && m.mr && m.dest != 0 && s.id_valid &&
               (m.dest == s.rs || m.dest == s.rt);
    endfunction

    // Value an EX operand sees: newest in-flight writer wins, r0 never forwarded.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] v,
                                            input stim_t s);
        if (r == 0) return v;
        if (s.xm_rw && s.xm_rd == r) return s.xm_res;
        if (s.mw_rw && s.mw_rd == r) return s.mw_res;
        return v;
    endfunction

    // Register read at ID, including a write landing in the same cycle.
    function automatic logic [31:0] id_read(input logic [4:0] r, input logic [31:0] v,
                                            input stim_t s);
        if (r != 0 && s.mw_rw && s.mw_rd == r) return s.mw_res;
        return v;
    endfunction

    function automatic ex_t advance(input ex_t m, input stim_t p);
        ex_t n;
        n = '0;
        if (p.rst || p.flush || load_use(m, p) || !p.id_valid) return n;
        n.valid   = 1'b1;
        n.rw      = p.reg_write;
        n.mr      = p.mem_read;
        n.mw      = p.mem_write;
        n.src_imm = p.src_imm;
        n.funct   = p.funct;
        n.op      = p.op;
        n.shamt   = p.shamt;
        n.rs      = p.rs;
        n.rt      = p.rt;
        n.dest    = p.reg_dst ? p.rd : p.rt;
        n.rs_val  = id_read(p.rs, p.rs_data, p);
        n.rt_val  = id_read(p.rt, p.rt_data, p);
        n.imm     = p.imm;
        return n;
    endfunction

    function automatic out_t predict(input ex_t m, input stim_t s);
        out_t o;
        o.stall = load_use(m, s) && !s.flush;
        o.valid = m.valid;
        o.rw    = m.rw;
        o.mr    = m.mr;
        o.mw    = m.mw;
        o.funct = m.funct;
        o.op    = m.op;
        o.shamt = m.shamt;
        o.src1  = operand(m.rs, m.rs_val, s);
        o.store = operand(m.rt, m.rt_val, s);
        o.src2  = m.src_imm ? m.imm : o.store;
        o.dest  = m.dest;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst;              id_valid = s.id_valid;
        id_rs_data = s.rs_data;   id_rt_data = s.rt_data;  id_imm = s.imm;
        id_rs = s.rs;             id_rt = s.rt;            id_rd = s.rd;
        id_funct = s.funct;       id_shamt = s.shamt;      id_op = s.op;
        id_alu_src_imm = s.src_imm; id_reg_dst = s.reg_dst;
        id_reg_write = s.reg_write; id_mem_read = s.mem_read; id_mem_write = s.mem_write;
        flush = s.flush;
        exmem_reg_write = s.xm_rw; exmem_rd = s.xm_rd; exmem_result = s.xm_res;
        memwb_reg_write = s.mw_rw; memwb_rd = s.mw_rd; memwb_result = s.mw_res;
    endtask

    // One cycle: retire the edge into the model, drive new inputs, queue expectation.
    task automatic issue(input stim_t s);
        @(posedge clk);
        model = advance(model, prev);
        #1;
        apply(s);
        prev = s;
        exp_q.push_back(predict(model, s));
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst       = ($urandom_range(0, 49) == 0);
        s.id_valid  = ($urandom_range(0, 9) != 0);
        s.rs_data   = $urandom;
        s.rt_data   = $urandom;
        s.imm       = $urandom;
        s.rs        = 5'($urandom_range(0, 7));
        s.rt        = 5'($urandom_range(0, 7));
        s.rd        = 5'($urandom_range(0, 7));
        s.funct     = 6'($urandom);
        s.shamt     = 5'($urandom);
        s.op        = 2'($urandom);
        s.src_imm   = 1'($urandom);
        s.reg_dst   = 1'($urandom);
        s.reg_write = 1'($urandom);
        s.mem_read  = ($urandom_range(0, 2) == 0);
        s.mem_write = 1'($urandom);
        s.flush     = ($urandom_range(0, 9) == 0);
        s.xm_rw     = 1'($urandom);
        s.xm_rd     = 5'($urandom_range(0, 7));
        s.xm_res    = $urandom;
        s.mw_rw     = 1'($urandom);
        s.mw_rd     = 5'($urandom_range(0, 7));
        s.mw_res    = $urandom;
        return s;
    endfunction

    // Monitor: compare the full EX-side output bundle every cycle an expectation exists.
    initial begin
        out_t act, exp_o;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_o = exp_q.pop_front();
                act = {stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_funct,
                       ex_op, ex_shamt, ex_src1, ex_src2, ex_store_data, ex_dest};
                n_checks++;
                if (act !== exp_o) begin
                    n_fail++;
                    $display("FAIL ex_outputs @%0t: got stall=%b v=%b rw/mr/mw=%b%b%b f=%h op=%b sh=%h s1=%h s2=%h sd=%h d=%0d; want stall=%b v=%b rw/mr/mw=%b%b%b f=%h op=%b sh=%h s1=%h s2=%h sd=%h d=%0d",
                             $time, act.stall, act.valid, act.rw, act.mr, act.mw, act.funct,
                             act.op, act.shamt, act.src1, act.src2, act.store, act.dest,
                             exp_o.stall, exp_o.valid, exp_o.rw, exp_o.mr, exp_o.mw,
                             exp_o.funct, exp_o.op, exp_o.shamt, exp_o.src1, exp_o.src2,
                             exp_o.store, exp_o.dest);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        model = '0;
        prev = nop();
        prev.rst = 1'b1;
        apply(prev);

        // Reset with a live, random instruction in ID.
        s = rand_stim(); s.rst = 1'b1; s.id_valid = 1'b1; s.flush = 1'b0;
        issue(s);
        issue(s);
        issue(nop());

        // EX/MEM beats MEM/WB, then MEM/WB alone, then r0 never forwarded.
        for (int k = 0; k < 3; k++) begin
            s = nop(); s.id_valid = 1'b1; s.rs = (k == 2) ? 5'd0 : 5'd3;
            s.rs_data = 32'h55; s.rd = 5'd4; s.reg_dst = 1'b1; s.reg_write = 1'b1;
            issue(s);
            s = nop();
            s.xm_rw = (k != 1); s.xm_rd = (k == 2) ? 5'd0 : 5'd3; s.xm_res = 32'h11;
            s.mw_rw = 1'b1;     s.mw_rd = (k == 2) ? 5'd0 : 5'd3; s.mw_res = 32'h22;
            issue(s);
        end

        // Load-use: lw r5 then add rs=5; one stall, a bubble, then forward from WB.
        s = nop(); s.id_valid = 1'b1; s.rt = 5'd5; s.src_imm = 1'b1; s.imm = 32'h40;
        s.mem_read = 1'b1; s.reg_write = 1'b1;
        issue(s);
        s = nop(); s.id_valid = 1'b1; s.rs = 5'd5; s.rt = 5'd2; s.rd = 5'd9;
        s.reg_dst = 1'b1; s.reg_write = 1'b1; s.op = 2'b10; s.funct = 6'h20;
        s.rs_data = 32'h1;
        issue(s);
        s.xm_rw = 1'b1; s.xm_rd = 5'd5; s.xm_res = 32'h40;
        issue(s);
        s = nop(); s.mw_rw = 1'b1; s.mw_rd = 5'd5; s.mw_res = 32'hD00D;
        issue(s);

        // Write-through capture on rt.
        s = nop(); s.id_valid = 1'b1; s.rt = 5'd7; s.rt_data = 32'h0; s.mem_write = 1'b1;
        s.mw_rw = 1'b1; s.mw_rd = 5'd7; s.mw_res = 32'hABCD;
        issue(s);
        issue(nop());

        // Immediate selects src2 while store data still forwards.
        s = nop(); s.id_valid = 1'b1; s.rt = 5'd4; s.src_imm = 1'b1; s.imm = 32'hFFFFFFFC;
        s.rt_data = 32'h3;
        issue(s);
        s = nop(); s.xm_rw = 1'b1; s.xm_rd = 5'd4; s.xm_res = 32'h99;
        issue(s);

        // Flush coinciding with a load-use hazard, then a normal capture.
        s = nop(); s.id_valid = 1'b1; s.rt = 5'd6; s.mem_read = 1'b1; s.reg_write = 1'b1;
        issue(s);
        s = nop(); s.id_valid = 1'b1; s.rs = 5'd6; s.reg_write = 1'b1; s.flush = 1'b1;
        issue(s);
        s = nop(); s.id_valid = 1'b1; s.rs = 5'd1; s.rs_data = 32'h77; s.rt = 5'd2;
        s.reg_write = 1'b1; s.funct = 6'h22; s.op = 2'b01; s.shamt = 5'd3;
        issue(s);
        issue(nop());

        // Reset while a stall is pending.
        s = nop(); s.id_valid = 1'b1; s.rt = 5'd5; s.mem_read = 1'b1;
        issue(s);
        s = nop(); s.id_valid = 1'b1; s.rs = 5'd5; s.rst = 1'b1;
        issue(s);
        s.rst = 1'b0;
        issue(s);

        for (int i = 0; i < 3000; i++) issue(rand_stim());
        issue(nop());

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_operand_issue.md
Name: ex_operand_issue

Overview:
- ID/EX pipeline stage that produces every ALU input: funct, op, shamt, Src1 and Src2.
- Registers the decoded instruction and resolves data hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls IF/ID and inserts a bubble.
- Handles branch flush.
- Sits between the decode stage and the ALU; the ALU result feeds back through the EX/MEM and MEM/WB forwarding inputs.

Parameters:
- WIDTH, 32, datapath width
- RBITS, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs_data, id_rt_data  in  WIDTH  register file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_rs, id_rt, id_rd  in  RBITS  register addresses
- id_funct  in  6  function field
- id_shamt  in  5  shift amount
- id_op  in  2  ALU op: 00 add, 01 sub, 10 use funct
- id_alu_src_imm, id_reg_dst, id_reg_write, id_mem_read, id_mem_write  in  1  decoded controls
- flush  in  1  branch taken; discard the ID instruction
- exmem_reg_write  in  1
- exmem_rd  in  RBITS
- exmem_result  in  WIDTH
- memwb_reg_write  in  1
- memwb_rd  in  RBITS
- memwb_result  in  WIDTH
- stall  out  1  hold PC and IF/ID (combinational)
- ex_funct  out  6
- ex_op  out  2
- ex_shamt  out  5
- ex_src1, ex_src2  out  WIDTH  ALU operands
- ex_store_data  out  WIDTH  forwarded rt value for stores
- ex_dest  out  RBITS
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1

Behaviour:
- Reset: all registered state is cleared, so every ex_* output reads 0 and stall=0 in the cycle after rst is sampled high. Reset has priority over all other inputs.
- Hazard detect:
  - hz = ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | ex_dest==id_rt).
  - id_rt is compared regardless of id_alu_src_imm.
  - stall = hz & ~flush.
- Register update on each rising edge, priority rst > flush > hz > load:
  - flush or hz: bubble. All registered fields are zeroed, ex_valid=0, ex_op=00.
  - otherwise: capture every id_* field; ex_valid=id_valid.
  - id_valid=0 also loads zeroed controls.
  - There is no hold state. The stage never freezes; downstream stalls do not exist in this pipeline.
- Write-through capture at ID:
  - When loading, if memwb_reg_write & memwb_rd!=0 & memwb_rd==id_rs, the rs register captures memwb_result instead of id_rs_data.
  - The same rule applies to rt.
  - This covers the register file's same-cycle write.
- EX forwarding (combinational on registered rs/rt):
  - fwdA = exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs.
  - else fwdA = memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs.
  - else fwdA = the registered rs value.
  - EX/MEM beats MEM/WB. Register 0 is never forwarded. fwdB is built the same way from ex_rt.
- Outputs:
  - ex_src1 = fwdA.
  - ex_src2 = ex_alu_src_imm ? registered imm : fwdB.
  - ex_store_data = fwdB.
  - ex_dest = reg_dst ? rd : rt, computed at capture.
  - ex_funct, ex_shamt and ex_op are registered copies of the decode fields.
- Latency: one cycle from ID capture to EX outputs; forwarding adds zero cycles.
- Load in EX/MEM: exmem_result is an address there. The hz stall guarantees a dependent instruction is never in EX while the load is in EX/MEM, so no exmem_mem_read qualifier is needed.
- Flush and hz in the same cycle: bubble inserted, stall=0, and the wrong-path instruction is dropped.
- Reset during a stall: stall drops to 0 the cycle after reset, and the EX stage is empty.

Test Plan:
- Reset: drive rst=1 with id_valid=1 and random fields -> next cycle all ex_* outputs are 0 and stall=0.
- EX/MEM priority: add r3 with exmem_rd=3, exmem_result=0x11 and memwb_rd=3, memwb_result=0x22; next instruction uses rs=3 -> ex_src1=0x11. Repeat with exmem_reg_write=0 -> ex_src1=0x22. Repeat with rd=0 -> ex_src1 = the register value.
- Load-use: lw r5 in EX (ex_mem_read=1, ex_dest=5), ID holds add rs=5 -> stall=1 for one cycle and ex_valid=0 in the next cycle. The add then issues, and ex_src1 takes memwb_result once the load reaches MEM/WB.
- Write-through: memwb_rd=7, memwb_result=0xABCD with id_rt=7 and id_rt_data=0 -> ex_store_data=0xABCD when no newer writer matches.
- Immediate vs forwarding: id_alu_src_imm=1, id_imm=0xFFFFFFFC, rt forwarded 0x99 -> ex_src2=0xFFFFFFFC and ex_store_data=0x99.
- Flush with hazard: flush=1 while hz conditions hold -> stall=0, next cycle ex_valid=0 with all controls 0, and the following instruction is captured normally.
